// File: rtl/mips_32_bit.sv
// mips_32_bit: single-cycle 32-bit MIPS subset CPU.
// PC, instruction ROM (preloaded hierarchically), 32x32 register file,
// ALU, control decode and a word-addressed data RAM.
// Optional macro MIPS_EXT_ALU_EN adds and/or/slt R-type decode; when it is
// undefined those functs execute as NOPs.
module mips_32_bit #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] PC_INIT    = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] pc,
    output logic [31:0] instruction
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
`ifdef MIPS_EXT_ALU_EN
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
`endif

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] regs [32];
    logic [31:0] dmem [DMEM_DEPTH];

    logic [5:0]         op;
    logic [5:0]         funct;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic [15:0]        imm16;
    logic [31:0]        rs_val;
    logic [31:0]        rt_val;
    logic signed [31:0] imm_ext;
    logic [31:0]        pc_plus4;
    logic [31:0]        br_target;
    logic [31:0]        next_pc;
    logic [31:0]        eff_addr;
    logic [DAW-1:0]     dmem_idx;
    logic [31:0]        dmem_rdata;
    logic               reg_we;
    logic               mem_we;
    logic               br_take;
    logic [4:0]         wr_addr;
    logic [31:0]        wr_data;
    logic               unused_bits;

    function automatic logic signed [31:0] sext16(input logic [15:0] v);
        return $signed({{16{v[15]}}, v});
    endfunction

    // Fetch: ROM word index wraps modulo IMEM_DEPTH via truncation
    assign instruction = imem[pc[IAW+1:2]];

    assign op    = instruction[31:26];
    assign rs    = instruction[25:21];
    assign rt    = instruction[20:16];
    assign rd    = instruction[15:11];
    assign funct = instruction[5:0];
    assign imm16 = instruction[15:0];

    // $0 is hard-wired to zero on the read side as well
    assign rs_val = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : regs[rt];

    assign imm_ext   = sext16(imm16);
    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + {imm_ext[29:0], 2'b00};

    // Byte offset bits are dropped; word index wraps modulo DMEM_DEPTH
    assign eff_addr   = rs_val + $unsigned(imm_ext);
    assign dmem_idx   = eff_addr[DAW+1:2];
    assign dmem_rdata = dmem[dmem_idx];

    assign unused_bits = ^{pc[1:0], pc[31:IAW+2], eff_addr[1:0], eff_addr[31:DAW+2]};

    // Decode and execute: write enables, writeback value and branch decision
    always_comb begin
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        br_take = 1'b0;
        wr_addr = 5'd0;
        wr_data = 32'd0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin
                        reg_we  = 1'b1;
                        wr_addr = rd;
                        wr_data = rs_val + rt_val;
                    end
                    FN_SUB: begin
                        reg_we  = 1'b1;
                        wr_addr = rd;
                        wr_data = rs_val - rt_val;
                    end
`ifdef MIPS_EXT_ALU_EN
                    FN_AND: begin
                        reg_we  = 1'b1;
                        wr_addr = rd;
                        wr_data = rs_val & rt_val;
                    end
                    FN_OR: begin
                        reg_we  = 1'b1;
                        wr_addr = rd;
                        wr_data = rs_val | rt_val;
                    end
                    FN_SLT: begin
                        reg_we  = 1'b1;
                        wr_addr = rd;
                        wr_data = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0;
                    end
`endif
                    default: ;
                endcase
            end
            OP_ADDI: begin
                reg_we  = 1'b1;
                wr_addr = rt;
                wr_data = rs_val + $unsigned(imm_ext);
            end
            OP_LW: begin
                reg_we  = 1'b1;
                wr_addr = rt;
                wr_data = dmem_rdata;
            end
            OP_SW:  mem_we  = 1'b1;
            OP_BEQ: br_take = (rs_val == rt_val);
            OP_BNE: br_take = (rs_val != rt_val);
            default: ;
        endcase
    end

    assign next_pc = br_take ? br_target : pc_plus4;

    // Architectural state: PC and register file, cleared by async reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= PC_INIT;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (start) begin
            pc <= next_pc;
            if (reg_we && (wr_addr != 5'd0)) begin
                regs[wr_addr] <= wr_data;
            end
        end
    end

    // Data RAM write; contents survive reset, writes blocked while reset is high
    always_ff @(posedge clk) begin
        if (start && mem_we && !reset) begin
            dmem[dmem_idx] <= rt_val;
        end
    end

endmodule

// File: tb/tb_mips_32_bit.sv
// tb_mips_32_bit: directed program bench for mips_32_bit with a
// scoreboard queue of expected architectural state.
module tb_mips_32_bit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] pc;
    logic [31:0] instruction;

    localparam int KIND_PC   = 0;
    localparam int KIND_REG  = 1;
    localparam int KIND_DMEM = 2;
    localparam int KIND_INST = 3;

`ifdef MIPS_EXT_ALU_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    mips_32_bit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pc          (pc),
        .instruction (instruction)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic push(input string tag, input int kind, input int idx, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int kind, input int idx);
        case (kind)
            KIND_PC:   return pc;
            KIND_REG:  return dut.regs[idx];
            KIND_DMEM: return dut.dmem[idx];
            default:   return instruction;
        endcase
    endfunction

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind, e.idx);
            checks++;
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // One clock with expected PC after the edge
    task automatic step(input string tag, input logic [31:0] exp_pc);
        push(tag, KIND_PC, 0, exp_pc);
        @(posedge clk);
        #1;
        drain();
    endtask

    logic [31:0] prog [21];
    logic [31:0] loop_pcs [9];

    initial begin
        prog = '{
            32'h00004020,  //  0 add  $t0,$0,$0
            32'h20090020,  //  1 addi $t1,$0,32
            32'h200B0004,  //  2 addi $t3,$0,4
            32'h2010000C,  //  3 addi $s0,$0,12
            32'h00008820,  //  4 add  $s1,$0,$0
            32'hAD300004,  //  5 sw   $s0,4($t1)
            32'h020B8022,  //  6 sub  $s0,$s0,$t3
            32'h022B8820,  //  7 add  $s1,$s1,$t3
            32'h1600FFFD,  //  8 bne  $s0,$0,-3
            32'h2130000C,  //  9 addi $s0,$t1,12
            32'h200C002C,  // 10 addi $t4,$0,44
            32'h120C0002,  // 11 beq  $s0,$t4,2
            32'h20080055,  // 12 addi $t0,$0,0x55 (skipped)
            32'h20080055,  // 13 addi $t0,$0,0x55 (skipped)
            32'h8D320004,  // 14 lw   $s2,4($t1)
            32'hAD920000,  // 15 sw   $s2,0($t4)
            32'h20000005,  // 16 addi $0,$0,5
            32'h012B6825,  // 17 or   $t5,$t1,$t3
            32'h0169702A,  // 18 slt  $t6,$t3,$t1
            32'h000B7822,  // 19 sub  $t7,$0,$t3
            32'h3C080123   // 20 lui  (unsupported -> NOP)
        };
        loop_pcs = '{32'd28, 32'd32, 32'd24, 32'd28, 32'd32, 32'd24, 32'd28, 32'd32, 32'd36};

        // Phase A: empty ROM, every word is a NOP
        for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0;
        reset = 1'b1;
        start = 1'b0;
        #1;
        push("reset_pc", KIND_PC, 0, 32'h0);
        push("reset_r8", KIND_REG, 8, 32'h0);
        drain();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        step("nop_pc1", 32'd4);
        step("nop_pc2", 32'd8);
        step("nop_pc3", 32'd12);
        for (int r = 0; r < 32; r++) push($sformatf("nop_reg%0d", r), KIND_REG, r, 32'h0);
        drain();

        // Phase B: load program and restart
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 21; i++) dut.imem[i] = prog[i];
        #1;
        push("reload_pc", KIND_PC, 0, 32'h0);
        push("reload_inst", KIND_INST, 0, 32'h00004020);
        drain();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;

        step("p2_pc1", 32'd4);
        step("p2_pc2", 32'd8);
        step("p2_pc3", 32'd12);
        step("p2_pc4", 32'd16);
        push("p2_t0", KIND_REG, 8, 32'h0);
        push("p2_t1", KIND_REG, 9, 32'h20);
        push("p2_t3", KIND_REG, 11, 32'h4);
        push("p2_s0", KIND_REG, 16, 32'hC);
        drain();

        step("p3_add_s1", 32'd20);
        step("p3_sw", 32'd24);
        push("p3_dmem9", KIND_DMEM, 9, 32'hC);
        drain();
        for (int i = 0; i < 9; i++) step($sformatf("loop_pc%0d", i), loop_pcs[i]);
        push("loop_s0", KIND_REG, 16, 32'h0);
        push("loop_s1", KIND_REG, 17, 32'hC);
        push("loop_inst", KIND_INST, 0, 32'h2130000C);
        drain();

        // start low freezes everything
        start = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("hold_pc%0d", i), 32'd36);
        push("hold_s0", KIND_REG, 16, 32'h0);
        push("hold_s1", KIND_REG, 17, 32'hC);
        push("hold_inst", KIND_INST, 0, 32'h2130000C);
        drain();
        start = 1'b1;

        step("p4_addi_s0", 32'd40);
        step("p4_addi_t4", 32'd44);
        step("p4_beq", 32'd56);
        push("p4_s0", KIND_REG, 16, 32'h2C);
        push("p4_t4", KIND_REG, 12, 32'h2C);
        push("p4_skip_t0", KIND_REG, 8, 32'h0);
        push("p4_inst14", KIND_INST, 0, 32'h8D320004);
        drain();

        step("p5_lw", 32'd60);
        push("p5_s2", KIND_REG, 18, 32'hC);
        drain();
        step("p5_sw", 32'd64);
        push("p5_dmem11", KIND_DMEM, 11, 32'hC);
        drain();

        step("zero_write", 32'd68);
        push("zero_r0", KIND_REG, 0, 32'h0);
        drain();

        step("ext_or", 32'd72);
        step("ext_slt", 32'd76);
        step("sub_wrap", 32'd80);
        push("ext_or_t5", KIND_REG, 13, EXT ? 32'h24 : 32'h0);
        push("ext_slt_t6", KIND_REG, 14, EXT ? 32'h1 : 32'h0);
        push("sub_wrap_t7", KIND_REG, 15, 32'hFFFFFFFC);
        drain();

        step("unsup_op", 32'd84);
        push("unsup_t0", KIND_REG, 8, 32'h0);
        drain();

        // Async reset mid-run, asserted while the clock is low
        @(negedge clk);
        reset = 1'b1;
        #1;
        push("async_rst_pc", KIND_PC, 0, 32'h0);
        push("async_rst_s0", KIND_REG, 16, 32'h0);
        push("async_rst_s1", KIND_REG, 17, 32'h0);
        push("dmem_kept9", KIND_DMEM, 9, 32'hC);
        push("dmem_kept11", KIND_DMEM, 11, 32'hC);
        drain();
        step("rst_held_pc", 32'd0);
        reset = 1'b0;
        step("post_rst_pc", 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
